// File: rtl/genetico_pkg.sv
// Shared constants, state encoding and the output-compare helper for the
// chromosome evaluation controller.
// Latency: n/a (package). Backpressure: n/a (package).
// Contents: chromosome geometry, phenotype I/O widths, fitness width, FSM codes.
package genetico_pkg;

    // Chromosome geometry: logic elements, output selectors and spare bits.
    localparam int N_LES     = 27;
    localparam int LE_W      = 15;
    localparam int N_OUTS    = 4;
    localparam int OUT_SEL_W = 6;
    localparam int SPARE_W   = 24;
    localparam int CHROM_W   = N_LES * LE_W + N_OUTS * OUT_SEL_W + SPARE_W;  // 453

    // Phenotype interface and score widths.
    localparam int IN_W    = 8;
    localparam int OUT_W   = N_OUTS;
    localparam int FIT_W   = IN_W + $clog2(OUT_W) + 1;   // holds 2^IN_W * OUT_W
    localparam int MATCH_W = $clog2(OUT_W + 1);          // per-vector match count

    // Bit counter must be able to reach CHROM_W itself (the "loaded" value).
    localparam int              CNT_W     = $clog2(CHROM_W + 1);
    localparam logic [CNT_W-1:0] CHROM_CNT = CNT_W'(CHROM_W);

    // FSM encoding.
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_EVAL  = 2'd1;
    localparam state_t S_DRAIN = 2'd2;
    localparam state_t S_DONE  = 2'd3;

    // Number of output bits on which the phenotype agrees with the expectation.
    function automatic logic [MATCH_W-1:0] match_count(input logic [OUT_W-1:0] got,
                                                       input logic [OUT_W-1:0] want);
        logic [OUT_W-1:0]   eq;
        logic [MATCH_W-1:0] n;
        eq = ~(got ^ want);
        n  = '0;
        for (int i = 0; i < OUT_W; i++) begin
            n = n + MATCH_W'(eq[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/controlador_avaliacao_carregador_serial.sv
// Serial chromosome loader: right-shifting configuration register plus beat counter.
// Latency: a bit accepted at edge t is visible on cromossomo after edge t.
// Backpressure: serial_ready drops once CHROM_W bits are held or when not idle.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   idle              controller is in IDLE (loading allowed)
//   clr               discard bit count (register contents kept); wins over a beat
//   serial_in/_valid  bit stream in;  serial_ready  beat accepted this cycle
//   cromossomo        configuration register;  loaded  all CHROM_W bits present
module carregador_serial
    import genetico_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               idle,
    input  logic               clr,
    input  logic               serial_in,
    input  logic               serial_valid,
    output logic               serial_ready,
    output logic [CHROM_W-1:0] cromossomo,
    output logic               loaded
);

    logic [CHROM_W-1:0] crom_q, crom_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               ready;

    always_comb begin
        ready     = idle && (bit_cnt_q < CHROM_CNT);
        crom_d    = crom_q;
        bit_cnt_d = bit_cnt_q;
        if (clr) begin
            // Only the count is dropped; the phenotype keeps seeing the old
            // configuration until new bits shift in.
            bit_cnt_d = '0;
        end else if (serial_valid && ready) begin
            // First bit sent ends up in bit 0 after CHROM_W beats.
            crom_d    = {serial_in, crom_q[CHROM_W-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crom_q    <= '0;
            bit_cnt_q <= '0;
        end else begin
            crom_q    <= crom_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign serial_ready = ready;
    assign cromossomo   = crom_q;
    assign loaded       = (bit_cnt_q == CHROM_CNT);

endmodule

// File: rtl/controlador_avaliacao.sv
// Evaluation sequencer: loads a chromosome, sweeps all 2^IN_W phenotype inputs, scores matches.
// Latency: start accepted at edge t -> done/fitness visible after edge t+2^IN_W+2.
// Backpressure: serial_ready low outside IDLE or once loaded; start/clear ignored while busy.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   serial_in/_valid/_ready        chromosome bit stream (one bit per accepted beat)
//   clear                          drop partial/complete chromosome (IDLE only)
//   start                          begin evaluation (needs loaded)
//   cromossomo                     static configuration driven to the phenotype
//   chromIn / chromOut             phenotype test vector / its response
//   exp_addr / exp_data            truth-table ROM address / data one cycle later
//   loaded, busy, done, fitness    status, 1-cycle completion pulse, matching-bit score
module controlador_avaliacao
    import genetico_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               serial_in,
    input  logic               serial_valid,
    output logic               serial_ready,
    input  logic               clear,
    input  logic               start,
    output logic [CHROM_W-1:0] cromossomo,
    output logic [IN_W-1:0]    chromIn,
    input  logic [OUT_W-1:0]   chromOut,
    output logic [IN_W-1:0]    exp_addr,
    input  logic [OUT_W-1:0]   exp_data,
    output logic               loaded,
    output logic               busy,
    output logic               done,
    output logic [FIT_W-1:0]   fitness
);

    state_t            state_q, state_d;
    logic [IN_W-1:0]   vec_cnt_q, vec_cnt_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              valid_q, valid_d;
    logic [FIT_W-1:0]  acc_q, acc_d;
    logic [FIT_W-1:0]  fitness_q, fitness_d;
    logic              done_q, done_d;

    logic              idle;
    logic              load_clr;

    assign idle = (state_q == S_IDLE);
    // A finished evaluation consumes the chromosome, so DONE also clears the count.
    assign load_clr = (idle && clear) || (state_q == S_DONE);

    carregador_serial u_carregador (
        .clk          (clk),
        .rst_n        (rst_n),
        .idle         (idle),
        .clr          (load_clr),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .serial_ready (serial_ready),
        .cromossomo   (cromossomo),
        .loaded       (loaded)
    );

    always_comb begin
        state_d   = state_q;
        vec_cnt_d = vec_cnt_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        acc_d     = acc_q;
        fitness_d = fitness_q;
        done_d    = 1'b0;

        // Compare stage: the response captured last cycle meets the ROM word
        // for the same address, which arrives one cycle after exp_addr.
        if (valid_q) begin
            acc_d = acc_q + FIT_W'(match_count(out_q, exp_data));
        end

        case (state_q)
            S_IDLE: begin
                vec_cnt_d = '0;
                if (start && loaded) begin
                    state_d = S_EVAL;
                    acc_d   = '0;
                end
            end
            S_EVAL: begin
                out_d   = chromOut;
                valid_d = 1'b1;
                if (vec_cnt_q == '1) begin
                    state_d   = S_DRAIN;
                    vec_cnt_d = '0;
                end else begin
                    vec_cnt_d = vec_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Absorbs the compare of the last vector.
                state_d = S_DONE;
            end
            S_DONE: begin
                fitness_d = acc_q;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            vec_cnt_q <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            acc_q     <= '0;
            fitness_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_cnt_q <= vec_cnt_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            acc_q     <= acc_d;
            fitness_q <= fitness_d;
            done_q    <= done_d;
        end
    end

    assign chromIn  = vec_cnt_q;
    assign exp_addr = vec_cnt_q;
    assign busy     = (state_q == S_EVAL) || (state_q == S_DRAIN);
    assign done     = done_q;
    assign fitness  = fitness_q;

endmodule
